// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - DAC command word layout, NOP word and mode encodings
package dac_pkg;

    localparam int DAC_WORD_W = 16;
    localparam int CH_MSB     = 15;
    localparam int MODE_MSB   = 13;
    localparam int DATA_MSB   = 11;

    // Address 2'b11 is ignored by the DAC, so this keeps frames flowing harmlessly.
    localparam logic [DAC_WORD_W-1:0] NOP_WORD = 16'hC000;

    typedef enum logic [1:0] {
        MODE_NORMAL  = 2'b00,
        MODE_PD_1K   = 2'b01,
        MODE_PD_100K = 2'b10,
        MODE_PD_HIZ  = 2'b11
    } dac_mode_e;

    function automatic logic [DAC_WORD_W-1:0] pack_word(
        input logic [1:0]        ch,
        input logic [1:0]        mode,
        input logic [DATA_MSB:0] sample
    );
        logic [DAC_WORD_W-1:0] word;
        word                   = '0;
        word[CH_MSB -: 2]      = ch;
        word[MODE_MSB -: 2]    = mode;
        word[DATA_MSB:0]       = sample;
        return word;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter searching from a pointer
module rr_arbiter #(
    parameter int N_CH = 2
) (
    input  logic [N_CH-1:0] req_i,
    input  logic [1:0]      ptr_i,
    input  logic            grant_en_i,
    output logic [N_CH-1:0] grant_o,
    output logic [1:0]      winner_o,
    output logic            any_o
);

    always_comb begin
        grant_o  = '0;
        winner_o = '0;
        any_o    = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (!any_o && req_i[(int'(ptr_i) + k) % N_CH]) begin
                any_o                               = 1'b1;
                winner_o                            = 2'((int'(ptr_i) + k) % N_CH);
                grant_o[(int'(ptr_i) + k) % N_CH]   = grant_en_i;
            end
        end
    end

endmodule

// File: rtl/dac_frame_scheduler.sv
// rtl/dac_frame_scheduler.sv - stages one channel sample per DAC frame, NOP when idle
module dac_frame_scheduler
    import dac_pkg::*;
#(
    parameter int          N_CH     = 2,
    parameter int          DATA_W   = 12,
    parameter logic [15:0] NOP_WORD = dac_pkg::NOP_WORD
) (
    input  logic                     CLK1MHz,
    input  logic                     Reset_n,
    input  logic [N_CH-1:0]          ReqValid,
    input  logic [N_CH*DATA_W-1:0]   ReqData,
    output logic [N_CH-1:0]          ReqReady,
    input  logic [1:0]               Mode,
    input  logic                     Sync,
    output logic [DAC_WORD_W-1:0]    DinParalelo,
    output logic [N_CH-1:0]          Sent,
    output logic                     Idle
);

    logic                  sync_q;
    logic [N_CH-1:0]       pending_q, pending_d;
    logic [N_CH-1:0]       ready_q, ready_d;
    logic [N_CH-1:0]       sent_q, sent_d;
    logic [DATA_W-1:0]     data_q [N_CH];
    logic [DAC_WORD_W-1:0] word_q, word_d;
    logic                  stage_valid_q, stage_valid_d;
    logic [1:0]            stage_ch_q, stage_ch_d;
    logic [1:0]            ptr_q, ptr_d;
    logic                  idle_q, idle_d;

    logic                  commit;
    logic                  idle_fill;
    logic                  grant_en;
    logic [N_CH-1:0]       accept;
    logic [N_CH-1:0]       arb_grant;
    logic [1:0]            arb_winner;
    logic                  arb_any;
    logic [DATA_W-1:0]     win_data;

    // Only the falling edge of Sync commits, so a stuck-high Sync never repeats a word.
    assign commit    = sync_q && !Sync;
    assign idle_fill = !Sync && !stage_valid_q && !commit && arb_any;
    assign grant_en  = idle_fill || commit;
    assign accept    = ReqValid & ready_q;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req_i      (pending_q),
        .ptr_i      (ptr_q),
        .grant_en_i (grant_en),
        .grant_o    (arb_grant),
        .winner_o   (arb_winner),
        .any_o      (arb_any)
    );

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (arb_winner == 2'(i)) win_data = data_q[i];
        end
    end

    always_comb begin
        word_d        = word_q;
        stage_valid_d = stage_valid_q;
        stage_ch_d    = stage_ch_q;
        ptr_d         = ptr_q;
        pending_d     = (pending_q & ~arb_grant) | accept;
        for (int i = 0; i < N_CH; i++) begin
            sent_d[i] = commit && stage_valid_q && (stage_ch_q == 2'(i));
        end
        if (grant_en) begin
            if (arb_any) begin
                word_d        = pack_word(arb_winner, Mode, win_data);
                stage_valid_d = 1'b1;
                stage_ch_d    = arb_winner;
                ptr_d         = 2'((int'(arb_winner) + 1) % N_CH);
            end else begin
                word_d        = NOP_WORD;
                stage_valid_d = 1'b0;
            end
        end
        ready_d = ~pending_d;
        idle_d  = !stage_valid_d && (pending_d == '0);
    end

    always_ff @(posedge CLK1MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q        <= 1'b0;
            pending_q     <= '0;
            ready_q       <= '1;
            sent_q        <= '0;
            word_q        <= NOP_WORD;
            stage_valid_q <= 1'b0;
            stage_ch_q    <= '0;
            ptr_q         <= '0;
            idle_q        <= 1'b1;
        end else begin
            sync_q        <= Sync;
            pending_q     <= pending_d;
            ready_q       <= ready_d;
            sent_q        <= sent_d;
            word_q        <= word_d;
            stage_valid_q <= stage_valid_d;
            stage_ch_q    <= stage_ch_d;
            ptr_q         <= ptr_d;
            idle_q        <= idle_d;
        end
    end

    always_ff @(posedge CLK1MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < N_CH; i++) data_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (accept[i]) data_q[i] <= ReqData[i*DATA_W +: DATA_W];
            end
        end
    end

    assign ReqReady    = ready_q;
    assign DinParalelo = word_q;
    assign Sent        = sent_q;
    assign Idle        = idle_q;

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// tb/tb_dac_frame_scheduler.sv - directed scoreboard bench for dac_frame_scheduler
module tb_dac_frame_scheduler;

    localparam logic [15:0] NOP = 16'hC000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [23:0] req_data;
    logic [1:0]  req_ready;
    logic [1:0]  mode;
    logic        sync;
    logic [15:0] din;
    logic [1:0]  sent;
    logic        idle;

    typedef struct {
        logic [1:0]  ch;
        logic [15:0] word;
    } exp_t;

    exp_t        sb[$];
    int          n_pass   = 0;
    int          n_checks = 0;
    logic        prev_sync = 1'b0;
    logic [15:0] captured  = NOP;

    always #5 clk = ~clk;

    dac_frame_scheduler #(.N_CH(2), .DATA_W(12), .NOP_WORD(16'hC000)) dut (
        .CLK1MHz     (clk),
        .Reset_n     (rst_n),
        .ReqValid    (req_valid),
        .ReqData     (req_data),
        .ReqReady    (req_ready),
        .Mode        (mode),
        .Sync        (sync),
        .DinParalelo (din),
        .Sent        (sent),
        .Idle        (idle)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Models the transmitter: captures during Sync high, commits on the cycle after Sync falls.
    task automatic step();
        logic [15:0] din_before;
        logic        commit_cyc;
        logic        was_sync;
        logic [1:0]  exp_sent;
        exp_t        e;
        din_before = din;
        was_sync   = sync;
        if (sync) captured = din;
        commit_cyc = prev_sync && !sync;
        prev_sync  = sync;
        @(posedge clk);
        #1;
        if (was_sync) check("freeze", din, din_before);
        exp_sent = 2'b00;
        if (commit_cyc && captured !== NOP) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("word", captured, e.word);
                exp_sent = 2'(1 << e.ch);
            end else begin
                check("unexpected_word", captured, NOP);
            end
        end
        check("sent", sent, exp_sent);
    endtask

    task automatic frame(input int n_low);
        sync = 1'b1;
        step();
        sync = 1'b0;
        repeat (n_low) step();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_data  = '0;
        mode      = 2'b00;
        sync      = 1'b0;
        #12;
        check("rst_din", din, NOP);
        check("rst_ready", req_ready, 2'b11);
        check("rst_sent", sent, 2'b00);
        check("rst_idle", idle, 1'b1);
        rst_n = 1'b1;

        // Free-running frames with no requests
        repeat (2) frame(17);
        check("s1_din", din, NOP);
        check("s1_idle", idle, 1'b1);

        // Single sample on ch0
        req_data[11:0] = 12'hABC;
        req_valid      = 2'b01;
        sb.push_back('{2'd0, 16'h0ABC});
        step();
        req_valid = 2'b00;
        check("s2_not_yet", din, NOP);
        check("s2_ready", req_ready, 2'b10);
        step();
        check("s2_staged", din, 16'h0ABC);
        check("s2_idle_busy", idle, 1'b0);
        frame(17);
        check("s2_back_nop", din, NOP);
        check("s2_idle", idle, 1'b1);

        // Both channels continuously, then drain
        req_data  = {12'h222, 12'h111};
        req_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{2'd1, 16'h4222});
            sb.push_back('{2'd0, 16'h0111});
        end
        repeat (3) step();
        check("s3_first", din, 16'h4222);
        repeat (3) frame(17);
        req_valid = 2'b00;
        repeat (4) frame(17);
        check("s3_drained", din, NOP);
        check("s3_idle", idle, 1'b1);

        // Request arriving during the Sync cycle with empty stage
        sync            = 1'b1;
        req_valid       = 2'b10;
        req_data[23:12] = 12'h5A5;
        mode            = 2'b01;
        sb.push_back('{2'd1, 16'h55A5});
        step();
        check("s4_frozen", din, NOP);
        req_valid = 2'b00;
        sync      = 1'b0;
        step();
        check("s4_commit_stage", din, 16'h55A5);
        mode = 2'b11;
        repeat (16) step();
        frame(17);
        check("s4_done", din, NOP);

        // Sync held high for 10 cycles
        mode           = 2'b00;
        req_data[11:0] = 12'h321;
        req_valid      = 2'b01;
        sb.push_back('{2'd0, 16'h0321});
        step();
        req_valid = 2'b00;
        step();
        check("s5_staged", din, 16'h0321);
        sync = 1'b1;
        repeat (10) step();
        sync = 1'b0;
        repeat (17) step();
        check("s5_done", din, NOP);

        // Async reset mid-frame with both slots pending
        req_data  = {12'h888, 12'h777};
        req_valid = 2'b11;
        repeat (3) step();
        check("s6_pending", req_ready, 2'b00);
        req_valid = 2'b00;
        #3;
        rst_n = 1'b0;
        #1;
        check("s6_rst_din", din, NOP);
        check("s6_rst_ready", req_ready, 2'b11);
        check("s6_rst_sent", sent, 2'b00);
        check("s6_rst_idle", idle, 1'b1);
        #2;
        rst_n     = 1'b1;
        captured  = NOP;
        prev_sync = 1'b0;
        repeat (2) frame(17);
        check("s6_din", din, NOP);
        check("s6_idle", idle, 1'b1);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
